// File: rtl/tick_slot_arbiter_if.sv
// tick_slot_arbiter_if: tick, request and grant signals between requesters and the time-slice arbiter
interface tick_slot_arbiter_if #(parameter int N = 4, parameter int SLICE = 8);
   logic                           tick;
   logic [N-1:0]                   req;
   logic [N-1:0]                   gnt;
   logic [$clog2(N)-1:0]           gnt_id;
   logic                           busy;
   logic [$clog2(SLICE+1)-1:0]     ticks_left;
   logic                           expire;
   modport master (output tick, req, input gnt, gnt_id, busy, ticks_left, expire);
   modport slave (input tick, req, output gnt, gnt_id, busy, ticks_left, expire);
endinterface

// File: rtl/tick_slot_arbiter.sv
// tick_slot_arbiter: round-robin arbiter granting tick-measured slices with a one-cycle gap between grants
module tick_slot_arbiter #(
   parameter int N = 4,
   parameter int SLICE = 8
) (
   input logic clk,
   input logic rst,
   tick_slot_arbiter_if.slave bus
);
   localparam int IW = $clog2(N);
   localparam int TW = $clog2(SLICE + 1);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state, state_n;
   logic [N-1:0]  gnt_q, gnt_n;
   logic [IW-1:0] id_q, id_n, last_q, last_n, pick, idx;
   logic [TW-1:0] tl_q, tl_n;
   logic          exp_q, exp_n, found;
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         gnt_q  <= '0;
         id_q   <= '0;
         last_q <= IW'(N - 1);
         tl_q   <= '0;
         exp_q  <= 1'b0;
      end else begin
         state  <= state_n;
         gnt_q  <= gnt_n;
         id_q   <= id_n;
         last_q <= last_n;
         tl_q   <= tl_n;
         exp_q  <= exp_n;
      end
   end
   // search starts just after the previous owner so it ranks last
   always_comb begin
      pick  = last_q;
      idx   = '0;
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
         idx = IW'((int'(last_q) + i) % N);
         if (!found && bus.req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end
   always_comb begin
      state_n = state;
      gnt_n   = gnt_q;
      id_n    = id_q;
      last_n  = last_q;
      tl_n    = tl_q;
      exp_n   = 1'b0;
      if (state == IDLE) begin
         if (found) begin
            state_n = GRANT;
            gnt_n   = N'(1) << pick;
            id_n    = pick;
            last_n  = pick;
            tl_n    = TW'(SLICE);
         end
      end else if (!bus.req[id_q] || (bus.tick && tl_q == TW'(1))) begin
         state_n = IDLE;
         gnt_n   = '0;
         tl_n    = '0;
         exp_n   = bus.req[id_q];
      end else if (bus.tick) begin
         tl_n = tl_q - TW'(1);
      end
   end
   assign bus.gnt        = gnt_q;
   assign bus.gnt_id     = id_q;
   assign bus.busy       = |gnt_q;
   assign bus.ticks_left = tl_q;
   assign bus.expire     = exp_q;
endmodule
